// File: rtl/alu_pkg.sv
// Shared ALU select codes, RV32I opcodes and funct3 encodings used by the
// decode/issue path.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_B    = 4'd10;
    localparam logic [3:0] ALU_MUL  = 4'd11;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // OP / OP-IMM funct3
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // BRANCH funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

endpackage

// File: rtl/imm_gen.sv
// Combinational I/S/U immediate generator, sign-extended to WIDTH (WIDTH >= 32).
module imm_gen #(
    parameter int WIDTH = 32
) (
    input  logic [31:7]      instr,
    output logic [WIDTH-1:0] imm_i,
    output logic [WIDTH-1:0] imm_s,
    output logic [WIDTH-1:0] imm_u
);

    always_comb begin
        imm_i = WIDTH'($signed(instr[31:20]));
        imm_s = WIDTH'($signed({instr[31:25], instr[11:7]}));
        imm_u = WIDTH'($signed({instr[31:12], 12'b0}));
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Registered decode-to-execute stage driving ALU select/operands and branch
// qualifiers. Optional RV32M MUL decode enabled by macro ALU_ISSUE_MUL_EN.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int ALU_SEL = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [31:0]        instr,
    input  logic [WIDTH-1:0]   pc,
    input  logic [WIDTH-1:0]   rs1_data,
    input  logic [WIDTH-1:0]   rs2_data,
    input  logic               stall,
    input  logic               flush,
    output logic [ALU_SEL-1:0] alu_sel,
    output logic [WIDTH-1:0]   bus_a,
    output logic [WIDTH-1:0]   bus_b,
    output logic               out_valid,
    output logic               is_branch,
    output logic               branch_neg,
    output logic               illegal
);

    logic [WIDTH-1:0]   imm_i, imm_s, imm_u;
    logic [ALU_SEL-1:0] dec_sel;
    logic [WIDTH-1:0]   dec_a, dec_b;
    logic               dec_br, dec_neg, dec_ill;
    logic [6:0]         opcode, funct7;
    logic [2:0]         funct3;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    imm_gen #(.WIDTH(WIDTH)) u_imm_gen (
        .instr (instr[31:7]),
        .imm_i (imm_i),
        .imm_s (imm_s),
        .imm_u (imm_u)
    );

    always_comb begin
        dec_sel = ALU_SEL'(ALU_ADD);
        dec_a   = '0;
        dec_b   = '0;
        dec_br  = 1'b0;
        dec_neg = 1'b0;
        dec_ill = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_a = rs1_data;
                dec_b = rs2_data;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        F3_ADD:  dec_sel = ALU_SEL'(ALU_ADD);
                        F3_SLL:  dec_sel = ALU_SEL'(ALU_SLL);
                        F3_SLT:  dec_sel = ALU_SEL'(ALU_SLT);
                        F3_SLTU: dec_sel = ALU_SEL'(ALU_SLTU);
                        F3_XOR:  dec_sel = ALU_SEL'(ALU_XOR);
                        F3_SR:   dec_sel = ALU_SEL'(ALU_SRL);
                        F3_OR:   dec_sel = ALU_SEL'(ALU_OR);
                        default: dec_sel = ALU_SEL'(ALU_AND);
                    endcase
                end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
                    dec_sel = ALU_SEL'(ALU_SUB);
                end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
                    dec_sel = ALU_SEL'(ALU_SRA);
`ifdef ALU_ISSUE_MUL_EN
                end else if (funct7 == F7_MUL && funct3 == F3_ADD) begin
                    dec_sel = ALU_SEL'(ALU_MUL);
`endif
                end else begin
                    dec_ill = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec_a = rs1_data;
                dec_b = imm_i;
                case (funct3)
                    F3_ADD:  dec_sel = ALU_SEL'(ALU_ADD);
                    F3_SLT:  dec_sel = ALU_SEL'(ALU_SLT);
                    F3_SLTU: dec_sel = ALU_SEL'(ALU_SLTU);
                    F3_XOR:  dec_sel = ALU_SEL'(ALU_XOR);
                    F3_OR:   dec_sel = ALU_SEL'(ALU_OR);
                    F3_AND:  dec_sel = ALU_SEL'(ALU_AND);
                    F3_SLL: begin
                        dec_b   = WIDTH'(instr[24:20]);
                        dec_sel = ALU_SEL'(ALU_SLL);
                        dec_ill = (funct7 != F7_BASE);
                    end
                    default: begin
                        dec_b = WIDTH'(instr[24:20]);
                        if (funct7 == F7_BASE)     dec_sel = ALU_SEL'(ALU_SRL);
                        else if (funct7 == F7_ALT) dec_sel = ALU_SEL'(ALU_SRA);
                        else                       dec_ill = 1'b1;
                    end
                endcase
            end
            OPC_LOAD: begin
                dec_a = rs1_data;
                dec_b = imm_i;
            end
            OPC_STORE: begin
                dec_a = rs1_data;
                dec_b = imm_s;
            end
            OPC_BRANCH: begin
                dec_a  = rs1_data;
                dec_b  = rs2_data;
                dec_br = 1'b1;
                case (funct3)
                    F3_BEQ:  begin dec_sel = ALU_SEL'(ALU_SUB);  dec_neg = 1'b1; end
                    F3_BNE:        dec_sel = ALU_SEL'(ALU_SUB);
                    F3_BLT:  begin dec_sel = ALU_SEL'(ALU_SLT);  dec_neg = 1'b1; end
                    F3_BGE:        dec_sel = ALU_SEL'(ALU_SLT);
                    F3_BLTU: begin dec_sel = ALU_SEL'(ALU_SLTU); dec_neg = 1'b1; end
                    F3_BGEU:       dec_sel = ALU_SEL'(ALU_SLTU);
                    default:       dec_ill = 1'b1;
                endcase
            end
            OPC_LUI: begin
                dec_sel = ALU_SEL'(ALU_B);
                dec_b   = imm_u;
            end
            OPC_AUIPC: begin
                dec_a = pc;
                dec_b = imm_u;
            end
            OPC_JAL, OPC_JALR: begin
                dec_a = pc;
                dec_b = WIDTH'(4);
            end
            default: dec_ill = 1'b1;
        endcase
        // Illegal encodings present a neutral ADD 0+0 so EX never acts on garbage.
        if (dec_ill) begin
            dec_sel = ALU_SEL'(ALU_ADD);
            dec_a   = '0;
            dec_b   = '0;
            dec_br  = 1'b0;
            dec_neg = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_sel    <= ALU_SEL'(ALU_ADD);
            bus_a      <= '0;
            bus_b      <= '0;
            out_valid  <= 1'b0;
            is_branch  <= 1'b0;
            branch_neg <= 1'b0;
            illegal    <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            is_branch  <= 1'b0;
            branch_neg <= 1'b0;
            illegal    <= 1'b0;
        end else if (!stall) begin
            if (in_valid) begin
                alu_sel    <= dec_sel;
                bus_a      <= dec_a;
                bus_b      <= dec_b;
                out_valid  <= 1'b1;
                is_branch  <= dec_br;
                branch_neg <= dec_neg;
                illegal    <= dec_ill;
            end else begin
                out_valid  <= 1'b0;
            end
        end
    end

endmodule
